spi_ram_burst: RTL and testbench
================================

SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001: Parameter DATA_W, default 8, memory word width in bits.
REQ-002: Parameter MEM_DEPTH, default 256, number of words; any value 2..2**ADDR_SIZE.
REQ-003: Parameter ADDR_SIZE, default 8, address width; ADDR_SIZE <= DATA_W.
REQ-004: Parameter AUTO_INC, default 1; 1 enables address post-increment on data write/read, 0 disables it.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: rst_n  input  1  reset, asynchronous, active-low.
REQ-007: din  input  DATA_W+2  command word; din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
REQ-008: rx_valid  input  1  din valid this cycle; one command consumed per cycle while high.
REQ-009: clr_err  input  1  clears the sticky error flag.
REQ-010: dout  output  DATA_W  read data, registered.
REQ-011: tx_valid  output  1  dout valid, registered single-cycle pulse.
REQ-012: err  output  1  sticky out-of-range address error flag.

Function
REQ-013: Opcode 00 (rx_valid=1) SHALL load wr_addr <= din[ADDR_SIZE-1:0]; upper payload bits ignored.
REQ-014: Opcode 01 SHALL write din[DATA_W-1:0] to mem[wr_addr]; if AUTO_INC=1, wr_addr increments in the same cycle.
REQ-015: Opcode 10 SHALL load rd_addr <= din[ADDR_SIZE-1:0].
REQ-016: Opcode 11 SHALL register dout <= mem[rd_addr] and tx_valid <= 1 on the same edge (1-cycle latency from command edge); if AUTO_INC=1, rd_addr increments.
REQ-017: tx_valid SHALL be 0 in every cycle not following an accepted opcode-11 command; back-to-back opcode-11 commands yield tx_valid high on consecutive cycles.
REQ-018: dout SHALL hold its last value when tx_valid=0.
REQ-019: rx_valid=0 SHALL leave all state unchanged except tx_valid (cleared) and err (clr_err still acts).
REQ-020: Auto-increment SHALL wrap MEM_DEPTH-1 -> 0 (not 2**ADDR_SIZE-1 -> 0).
REQ-021: Opcode 00/10 with payload address >= MEM_DEPTH SHALL still load the pointer and set err.
REQ-022: Opcode 01 with wr_addr >= MEM_DEPTH SHALL not modify memory, SHALL set err, and SHALL not increment wr_addr.
REQ-023: Opcode 11 with rd_addr >= MEM_DEPTH SHALL drive dout <= 0, tx_valid <= 1, set err, not increment rd_addr.
REQ-024: clr_err=1 SHALL clear err next edge unless an error-setting event occurs in the same cycle; setting wins.
REQ-025: Read of a location written in the same cycle (opcode 11 cannot coincide with 01) is not possible; read after write on the next cycle SHALL return the new data.
REQ-026: Memory SHALL be inferable as single-port synchronous RAM; no reset of memory contents.

Reset
REQ-027: rst_n low SHALL asynchronously force dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0.
REQ-028: Memory contents SHALL be preserved across reset (undefined after power-up).
REQ-029: A command presented in the cycle rst_n deasserts SHALL be accepted on the first rising edge with rst_n high; reset mid-burst aborts the burst, pointers return to 0.

Verification
REQ-030: Defaults; cmds 00/0x10, 01/0xA5, 10/0x10, 11 -> next cycle dout=0xA5, tx_valid=1 for one cycle, err=0.
REQ-031: AUTO_INC=1; 00/0x00, 01 x4 with 0x11,0x22,0x33,0x44, 10/0x00, 11 x4 back-to-back -> dout 0x11,0x22,0x33,0x44 on 4 consecutive cycles, tx_valid high all 4.
REQ-032: MEM_DEPTH=200; 00/199, 01/0xAA, 01/0xBB -> mem[199]=0xAA, mem[0]=0xBB, err=0.
REQ-033: MEM_DEPTH=200; 10/250 -> err=1; 11 -> dout=0, tx_valid=1, rd_addr stays 250; clr_err alone -> err=0; clr_err with 11 same cycle -> err stays 1.
REQ-034: DATA_W=16, ADDR_SIZE=10, MEM_DEPTH=1024, AUTO_INC=0; write 0xBEEF at 1023, two reads at 1023 -> dout=0xBEEF twice, rd_addr unchanged.
REQ-035: Mid-burst rst_n pulse low -> dout=0, tx_valid=0, err=0 immediately; after release 11 reads mem[0]; previously written data intact.

Source files
------------

// File: rtl/spi_ram_burst.sv
// spi_ram_burst
//   Command-driven word memory with separate write and read pointers, meant to
//   sit behind a SPI slave that hands over one command word per cycle.
//   A command is {opcode[1:0], payload[DATA_W-1:0]}:
//     00  load the write pointer from the payload
//     01  write the payload at the write pointer (optionally post-incrementing)
//     10  load the read pointer from the payload
//     11  read at the read pointer (optionally post-incrementing)
//   Out-of-range pointers set a sticky error flag instead of touching memory.
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset (clears pointers, dout, flags)
//   din       command word {opcode, payload}
//   rx_valid  din is valid; one command is consumed per cycle while high
//   clr_err   clears err on the next edge (an error in the same cycle wins)
//   dout      registered read data, holds between reads
//   tx_valid  one-cycle pulse, dout carries a new read result
//   err       sticky out-of-range address error

module spi_ram_burst #(
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   input  logic              clr_err,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              err
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WRITE   = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_READ    = 2'b11
   } op_e;

   // Array index width; narrower than ADDR_SIZE when the memory is smaller
   // than the address space. Truncation is safe because every access is
   // range-checked first.
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
   localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

   logic [DATA_W-1:0]    mem [MEM_DEPTH];

   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [ADDR_SIZE-1:0] wr_addr_nxt;
   logic [ADDR_SIZE-1:0] rd_addr_nxt;

   op_e                  op;
   logic [DATA_W-1:0]    payload;
   logic [ADDR_SIZE-1:0] payload_addr;
   logic [IDX_W-1:0]     wr_idx;
   logic [IDX_W-1:0]     rd_idx;
   logic                 wr_ok;
   logic                 rd_ok;
   logic                 do_write;
   logic                 do_read;
   logic                 err_set;
   logic                 err_nxt;
   logic [DATA_W-1:0]    rd_word;

   function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
      return ({1'b0, a} < DEPTH_EXT);
   endfunction

   // Wrap at the configured depth, not at the top of the address space.
   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
   endfunction

   assign op           = op_e'(din[DATA_W+1:DATA_W]);
   assign payload      = din[DATA_W-1:0];
   assign payload_addr = din[ADDR_SIZE-1:0];
   assign wr_idx       = wr_addr[IDX_W-1:0];
   assign rd_idx       = rd_addr[IDX_W-1:0];
   assign wr_ok        = in_range(wr_addr);
   assign rd_ok        = in_range(rd_addr);

   always_comb begin
      wr_addr_nxt = wr_addr;
      rd_addr_nxt = rd_addr;
      do_write    = 1'b0;
      do_read     = 1'b0;
      err_set     = 1'b0;
      if (rx_valid) begin
         case (op)
            OP_WR_ADDR: begin
               // Pointer is loaded even when out of range so the error is
               // reported again on the access that follows.
               wr_addr_nxt = payload_addr;
               err_set     = !in_range(payload_addr);
            end
            OP_WRITE: begin
               if (wr_ok) begin
                  do_write = 1'b1;
                  if (AUTO_INC != 0) begin
                     wr_addr_nxt = next_addr(wr_addr);
                  end
               end else begin
                  err_set = 1'b1;
               end
            end
            OP_RD_ADDR: begin
               rd_addr_nxt = payload_addr;
               err_set     = !in_range(payload_addr);
            end
            OP_READ: begin
               do_read = 1'b1;
               if (rd_ok) begin
                  if (AUTO_INC != 0) begin
                     rd_addr_nxt = next_addr(rd_addr);
                  end
               end else begin
                  err_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      err_nxt = err;
      if (err_set) begin
         err_nxt = 1'b1;
      end else if (clr_err) begin
         err_nxt = 1'b0;
      end
   end

   // Memory array: no reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_idx] <= payload;
      end
   end

   // Only one of write/read can happen per cycle, so the array is accessed
   // through a single port.
   assign rd_word = rd_ok ? mem[rd_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr  <= '0;
         rd_addr  <= '0;
         dout     <= '0;
         tx_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_addr  <= wr_addr_nxt;
         rd_addr  <= rd_addr_nxt;
         tx_valid <= do_read;
         err      <= err_nxt;
         if (do_read) begin
            dout <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_burst.sv
module tb_spi_ram_burst;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance a: default parameters, checked through the scoreboard.
   logic       a_rst_n = 1'b0;
   logic [9:0] a_din   = '0;
   logic       a_rx    = 1'b0;
   logic       a_clr   = 1'b0;
   logic [7:0] a_dout;
   logic       a_tx;
   logic       a_err;

   // Instance b: MEM_DEPTH=200.
   logic       b_rst_n = 1'b0;
   logic [9:0] b_din   = '0;
   logic       b_rx    = 1'b0;
   logic       b_clr   = 1'b0;
   logic [7:0] b_dout;
   logic       b_tx;
   logic       b_err;

   // Instance c: 16-bit words, 1024 deep, no auto-increment.
   logic        c_rst_n = 1'b0;
   logic [17:0] c_din   = '0;
   logic        c_rx    = 1'b0;
   logic        c_clr   = 1'b0;
   logic [15:0] c_dout;
   logic        c_tx;
   logic        c_err;

   spi_ram_burst dut_a (
      .clk(clk), .rst_n(a_rst_n), .din(a_din), .rx_valid(a_rx), .clr_err(a_clr),
      .dout(a_dout), .tx_valid(a_tx), .err(a_err)
   );

   spi_ram_burst #(.MEM_DEPTH(200)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .din(b_din), .rx_valid(b_rx), .clr_err(b_clr),
      .dout(b_dout), .tx_valid(b_tx), .err(b_err)
   );

   spi_ram_burst #(.DATA_W(16), .ADDR_SIZE(10), .MEM_DEPTH(1024), .AUTO_INC(0)) dut_c (
      .clk(clk), .rst_n(c_rst_n), .din(c_din), .rx_valid(c_rx), .clr_err(c_clr),
      .dout(c_dout), .tx_valid(c_tx), .err(c_err)
   );

   // Reference model for instance a (depth 256, auto-increment on).
   logic [7:0] m_mem [256];
   logic [7:0] m_wr = '0;
   logic [7:0] m_rd = '0;
   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];
   int         obs_cyc [$];

   always @(negedge clk) begin
      if (a_tx === 1'b1) begin
         obs_q.push_back(a_dout);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic a_send(input logic [1:0] op, input logic [7:0] pl);
      @(negedge clk);
      a_din = {op, pl};
      a_rx  = 1'b1;
      case (op)
         2'd0: m_wr = pl;
         2'd1: begin m_mem[m_wr] = pl; m_wr = m_wr + 8'd1; end
         2'd2: m_rd = pl;
         default: begin exp_q.push_back(m_mem[m_rd]); m_rd = m_rd + 8'd1; end
      endcase
   endtask

   task automatic a_idle(input int n);
      repeat (n) begin
         @(negedge clk);
         a_rx  = 1'b0;
         a_din = '0;
      end
   endtask

   task automatic b_cmd(input logic [1:0] op, input logic [7:0] pl, input logic clr);
      @(negedge clk);
      b_din = {op, pl};
      b_rx  = 1'b1;
      b_clr = clr;
   endtask

   task automatic b_idle(input logic clr);
      @(negedge clk);
      b_din = '0;
      b_rx  = 1'b0;
      b_clr = clr;
   endtask

   task automatic c_cmd(input logic [1:0] op, input logic [15:0] pl);
      @(negedge clk);
      c_din = {op, pl};
      c_rx  = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++; if (a_dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", a_dout); end
      n_cmp++; if (a_tx !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", a_tx); end
      n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", a_err); end
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL reset_err_b: got %b want 0", b_err); end
      n_cmp++; if (c_dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout_c: got %h want 0000", c_dout); end
      @(negedge clk);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      c_rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] e, o;
      a_send(2'd0, 8'h10);
      a_send(2'd1, 8'hA5);
      a_send(2'd2, 8'h10);
      a_send(2'd3, 8'h00);
      a_idle(2);
      #1;
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL basic_dout: got %h want %h", o, e); end
      end
      n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", a_err); end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_back_to_back;
      a_send(2'd0, 8'h00);
      a_send(2'd1, 8'h11);
      a_send(2'd1, 8'h22);
      a_send(2'd1, 8'h33);
      a_send(2'd1, 8'h44);
      a_send(2'd2, 8'h00);
      repeat (4) a_send(2'd3, 8'h00);
      a_idle(2);
      #1;
      n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL burst_pulses: got %0d want 4", obs_q.size()); end
      if (obs_q.size() == 4 && exp_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL burst_dout[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            n_cmp++; if (obs_cyc[i] !== obs_cyc[0] + i) begin n_bad++; $display("FAIL burst_consecutive[%0d]: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
         end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_read_after_write;
      logic [7:0] e, o;
      a_send(2'd2, 8'h40);
      a_send(2'd0, 8'h40);
      a_send(2'd1, 8'h5A);
      a_send(2'd3, 8'h00);
      // wrap of the auto-increment at the top of a full-depth memory
      a_send(2'd0, 8'hFF);
      a_send(2'd1, 8'h01);
      a_send(2'd1, 8'h02);
      a_send(2'd2, 8'hFF);
      a_send(2'd3, 8'h00);
      a_send(2'd3, 8'h00);
      a_idle(2);
      #1;
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL raw_wrap_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL raw_wrap_dout: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_idle_hold;
      logic [7:0] e, o, held;
      a_send(2'd0, 8'h00);
      a_send(2'd2, 8'h00);
      a_send(2'd3, 8'h00);
      held = exp_q[exp_q.size() - 1];
      // a write command on din without rx_valid must be ignored
      repeat (3) begin
         @(negedge clk);
         a_rx  = 1'b0;
         a_din = {2'b01, 8'hEE};
      end
      n_cmp++; if (a_tx !== 1'b0) begin n_bad++; $display("FAIL idle_tx_valid: got %b want 0", a_tx); end
      n_cmp++; if (a_dout !== held) begin n_bad++; $display("FAIL idle_dout_hold: got %h want %h", a_dout, held); end
      a_send(2'd1, 8'h99);
      a_send(2'd2, 8'h00);
      a_send(2'd3, 8'h00);
      a_idle(2);
      #1;
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL idle_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL idle_dout: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_reset_mid_burst;
      logic [7:0] e, o;
      a_send(2'd2, 8'h00);
      a_send(2'd3, 8'h00);
      a_send(2'd3, 8'h00);
      @(negedge clk);
      a_din = {2'b11, 8'h00};
      a_rx  = 1'b1;
      #2 a_rst_n = 1'b0;
      #1;
      n_cmp++; if (a_dout !== 8'h00) begin n_bad++; $display("FAIL midrst_dout: got %h want 00", a_dout); end
      n_cmp++; if (a_tx !== 1'b0) begin n_bad++; $display("FAIL midrst_tx_valid: got %b want 0", a_tx); end
      n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", a_err); end
      m_wr = '0;
      m_rd = '0;
      a_rx = 1'b0;
      @(negedge clk);
      // command presented in the release cycle is taken on the next edge
      a_rst_n = 1'b1;
      a_din   = {2'b11, 8'h00};
      a_rx    = 1'b1;
      exp_q.push_back(m_mem[0]);
      m_rd = m_rd + 8'd1;
      a_send(2'd1, 8'h3C);
      a_send(2'd2, 8'h00);
      a_send(2'd3, 8'h00);
      a_idle(2);
      #1;
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midrst_dout_after: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_depth_wrap;
      b_cmd(2'd0, 8'd199, 1'b0);
      b_cmd(2'd1, 8'hAA, 1'b0);
      b_cmd(2'd1, 8'hBB, 1'b0);
      b_cmd(2'd2, 8'd199, 1'b0);
      b_cmd(2'd3, 8'h00, 1'b0);
      b_cmd(2'd3, 8'h00, 1'b0);
      n_cmp++; if (b_dout !== 8'hAA || b_tx !== 1'b1) begin n_bad++; $display("FAIL depth_mem199: got %h/%b want aa/1", b_dout, b_tx); end
      b_idle(1'b0);
      n_cmp++; if (b_dout !== 8'hBB || b_tx !== 1'b1) begin n_bad++; $display("FAIL depth_mem0: got %h/%b want bb/1", b_dout, b_tx); end
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL depth_err: got %b want 0", b_err); end
      b_idle(1'b0);
      n_cmp++; if (b_tx !== 1'b0) begin n_bad++; $display("FAIL depth_tx_drop: got %b want 0", b_tx); end
   endtask

   task automatic test_range_err;
      b_cmd(2'd2, 8'd250, 1'b0);
      b_cmd(2'd3, 8'h00, 1'b0);
      n_cmp++; if (b_err !== 1'b1) begin n_bad++; $display("FAIL oor_ptr_err: got %b want 1", b_err); end
      b_idle(1'b0);
      n_cmp++; if (b_dout !== 8'h00 || b_tx !== 1'b1) begin n_bad++; $display("FAIL oor_read: got %h/%b want 00/1", b_dout, b_tx); end
      b_idle(1'b1);
      b_idle(1'b0);
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL clr_err_alone: got %b want 0", b_err); end
      b_cmd(2'd3, 8'h00, 1'b1);
      b_idle(1'b0);
      n_cmp++; if (b_err !== 1'b1) begin n_bad++; $display("FAIL clr_vs_set: got %b want 1", b_err); end
      n_cmp++; if (b_dout !== 8'h00 || b_tx !== 1'b1) begin n_bad++; $display("FAIL oor_read2: got %h/%b want 00/1", b_dout, b_tx); end
      b_idle(1'b1);
      b_idle(1'b0);
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL clr_err_again: got %b want 0", b_err); end
      b_cmd(2'd0, 8'd210, 1'b0);
      b_idle(1'b1);
      b_idle(1'b0);
      b_cmd(2'd1, 8'h66, 1'b0);
      b_idle(1'b0);
      n_cmp++; if (b_err !== 1'b1) begin n_bad++; $display("FAIL oor_write_err: got %b want 1", b_err); end
      @(negedge clk);
      #2 b_rst_n = 1'b0;
      #1;
      n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL reset_clears_err: got %b want 0", b_err); end
      @(negedge clk);
      b_rst_n = 1'b1;
   endtask

   task automatic test_no_autoinc;
      c_cmd(2'd0, 16'd1023);
      c_cmd(2'd1, 16'hBEEF);
      c_cmd(2'd2, 16'd1023);
      c_cmd(2'd3, 16'h0000);
      c_cmd(2'd3, 16'h0000);
      n_cmp++; if (c_dout !== 16'hBEEF || c_tx !== 1'b1) begin n_bad++; $display("FAIL w16_read1: got %h/%b want beef/1", c_dout, c_tx); end
      c_cmd(2'd1, 16'h1234);
      n_cmp++; if (c_dout !== 16'hBEEF || c_tx !== 1'b1) begin n_bad++; $display("FAIL w16_read2: got %h/%b want beef/1", c_dout, c_tx); end
      c_cmd(2'd3, 16'h0000);
      n_cmp++; if (c_tx !== 1'b0) begin n_bad++; $display("FAIL w16_tx_after_write: got %b want 0", c_tx); end
      @(negedge clk);
      c_rx  = 1'b0;
      c_din = '0;
      n_cmp++; if (c_dout !== 16'h1234 || c_tx !== 1'b1) begin n_bad++; $display("FAIL w16_noinc: got %h/%b want 1234/1", c_dout, c_tx); end
      n_cmp++; if (c_err !== 1'b0) begin n_bad++; $display("FAIL w16_err: got %b want 0", c_err); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_read_after_write();
      test_idle_hold();
      test_reset_mid_burst();
      test_depth_wrap();
      test_range_err();
      test_no_autoinc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
